// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS232 receive and transmit paths.
`timescale 1ns/1ps
package rs232_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Floor of log base 2; returns 0 for inputs of 0 or 1.
  function automatic int log2(input longint value);
    int     r;
    longint v;
    r = 0;
    v = value;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_oversample_tick.sv
// Fractional phase accumulator producing a one-cycle tick at Baud*Oversampling.
`timescale 1ns/1ps
module rx_oversample_tick
  import rs232_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int     AccWidth = log2(longint'(ClkFrequency / Baud)) + 8;
  localparam longint Rate     = longint'(Baud) * longint'(Oversampling);
  // Pre-shift the rate down so Rate << (AccWidth - ShiftLimiter) stays within 32 bits.
  localparam longint Ovf          = Rate >> (31 - AccWidth);
  localparam int     ShiftLimiter = (Ovf > 0) ? log2(Ovf) + 1 : 0;
  localparam longint IncL =
    ((Rate << (AccWidth - ShiftLimiter)) + longint'(ClkFrequency >> (ShiftLimiter + 1)))
    / longint'(ClkFrequency >> ShiftLimiter);
  localparam logic [AccWidth:0] Inc = IncL[AccWidth:0];

  logic [AccWidth:0] acc_q, acc_d;

  always_comb begin
    acc_d = {1'b0, acc_q[AccWidth-1:0]} + Inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign tick = acc_q[AccWidth];

endmodule

// File: rtl/rs232_rx.sv
// Oversampling 8N1 receiver: synchronizer, hysteresis filter and framing FSM.
`timescale 1ns/1ps
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_ready,
  output logic                 frame_error,
  output logic                 idle
);

  localparam int               OsBits  = log2(longint'(Oversampling));
  localparam logic [OsBits-1:0] OsHalf = OsBits'(Oversampling / 2 - 1);
  localparam logic [OsBits-1:0] OsLast = OsBits'(Oversampling - 1);
  localparam logic [2:0]        LastBit = 3'(DATA_BITS - 1);

  generate
    if (Oversampling != 4 && Oversampling != 8 && Oversampling != 16) begin : g_bad_os
      $error("rs232_rx: Oversampling must be 4, 8 or 16");
    end
  endgenerate

  logic os_tick;

  rx_oversample_tick #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .Oversampling(Oversampling)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (os_tick)
  );

  logic [1:0]           sync_q, sync_d;
  logic [1:0]           filt_cnt_q, filt_cnt_d;
  logic                 rx_f_q, rx_f_d;
  rx_state_t            state_q, state_d;
  logic [OsBits-1:0]    os_cnt_q, os_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_ready_q, data_ready_d;
  logic                 frame_error_q, frame_error_d;
  logic                 idle_q, idle_d;

  // Filter: rx_f only flips once the saturating counter hits an end stop.
  always_comb begin
    sync_d     = {sync_q[0], rxd};
    filt_cnt_d = filt_cnt_q;
    rx_f_d     = rx_f_q;
    if (os_tick) begin
      if (sync_q[1] && filt_cnt_q != 2'd3)       filt_cnt_d = filt_cnt_q + 2'd1;
      else if (!sync_q[1] && filt_cnt_q != 2'd0) filt_cnt_d = filt_cnt_q - 2'd1;
      if (filt_cnt_d == 2'd3)      rx_f_d = 1'b1;
      else if (filt_cnt_d == 2'd0) rx_f_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    os_cnt_d      = os_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    data_ready_d  = 1'b0;
    frame_error_d = 1'b0;
    if (os_tick) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_f_q) begin
            os_cnt_d = '0;
            state_d  = RX_START;
          end
        end
        RX_START: begin
          os_cnt_d = os_cnt_q + OsBits'(1);
          if (os_cnt_q == OsHalf) begin
            if (!rx_f_q) begin
              os_cnt_d  = '0;
              bit_cnt_d = '0;
              state_d   = RX_DATA;
            end else begin
              state_d = RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          os_cnt_d = os_cnt_q + OsBits'(1);
          if (os_cnt_q == OsLast) begin
            shreg_d   = {rx_f_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LastBit) state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          os_cnt_d = os_cnt_q + OsBits'(1);
          if (os_cnt_q == OsLast) begin
            if (rx_f_q) begin
              data_d       = shreg_q;
              data_ready_d = 1'b1;
              state_d      = RX_IDLE;
            end else begin
              frame_error_d = 1'b1;
              state_d       = RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          if (rx_f_q) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
    idle_d = (state_d == RX_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      filt_cnt_q    <= 2'd3;
      rx_f_q        <= 1'b1;
      state_q       <= RX_IDLE;
      os_cnt_q      <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      data_q        <= '0;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      sync_q        <= sync_d;
      filt_cnt_q    <= filt_cnt_d;
      rx_f_q        <= rx_f_d;
      state_q       <= state_d;
      os_cnt_q      <= os_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      data_ready_q  <= data_ready_d;
      frame_error_q <= frame_error_d;
      idle_q        <= idle_d;
    end
  end

  assign data        = data_q;
  assign data_ready  = data_ready_q;
  assign frame_error = frame_error_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed and randomized frame stimulus for rs232_rx, checked against a frame-level model.
`timescale 1ns/1ps
module tb_rs232_rx;

  localparam int  ClkHz  = 1600000;
  localparam int  BaudR  = 100000;
  localparam int  Os     = 8;
  localparam real BitNs  = 160.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_error;
  logic       idle;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         exp_ready_n = 0;
  int         exp_fe_n    = 0;
  int         ready_n     = 0;
  int         fe_n        = 0;
  int         cyc         = 0;
  int         ready_cyc[$];

  rs232_rx #(
    .ClkFrequency(ClkHz),
    .Baud        (BaudR),
    .Oversampling(Os)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data       (data),
    .data_ready (data_ready),
    .frame_error(frame_error),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every data_ready must match the oldest byte the model expects.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (data_ready || frame_error)
        check("pulse_exclusive", {31'b0, data_ready & frame_error}, 32'd0);
      if (data_ready) begin
        ready_n++;
        ready_cyc.push_back(cyc);
        check("ready_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("rx_byte", {24'b0, data}, {24'b0, exp_q.pop_front()});
      end
      if (frame_error) fe_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_bit;
    #(bit_ns);
  endtask

  task automatic send_good(input logic [7:0] b, input real bit_ns);
    exp_q.push_back(b);
    exp_ready_n++;
    last_good = b;
    send_frame(b, 1'b1, bit_ns);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    #(n * BitNs);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ready_count"}, ready_n, exp_ready_n);
    check({tag, "_fe_count"}, fe_n, exp_fe_n);
    check({tag, "_data"}, {24'b0, data}, {24'b0, last_good});
  endtask

  initial begin
    int         n0;
    int         gap;
    logic [7:0] b;
    real        scale;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_data", {24'b0, data}, 32'h00);
    check("reset_data_ready", {31'b0, data_ready}, 32'd0);
    check("reset_frame_error", {31'b0, frame_error}, 32'd0);
    check("reset_idle", {31'b0, idle}, 32'd1);
    #3 rst_n = 1'b1;
    idle_bits(2);

    // Single byte
    send_good(8'hA5, BitNs);
    idle_bits(3);
    check_counts("a5");
    check("a5_idle", {31'b0, idle}, 32'd1);

    // Back-to-back, no idle gap
    n0 = ready_cyc.size();
    send_good(8'h00, BitNs);
    send_good(8'hFF, BitNs);
    idle_bits(3);
    check_counts("b2b");
    check("b2b_pulses", ready_cyc.size() - n0, 32'd2);
    if (ready_cyc.size() >= n0 + 2) begin
      gap = ready_cyc[n0 + 1] - ready_cyc[n0];
      check("b2b_gap_150_170", {31'b0, (gap >= 150) && (gap <= 170)}, 32'd1);
    end

    // Short glitch on idle line
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    idle_bits(3);
    check_counts("glitch");
    check("glitch_idle", {31'b0, idle}, 32'd1);

    // Bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0, BitNs);
    exp_fe_n++;
    rxd = 1'b0;
    #(40 * BitNs);
    check_counts("break");
    check("break_not_idle", {31'b0, idle}, 32'd0);
    idle_bits(2);
    check("break_exit_idle", {31'b0, idle}, 32'd1);
    send_good(8'h5A, BitNs);
    idle_bits(3);
    check_counts("after_break");

    // Reset in the middle of a frame
    rxd = 1'b0;
    #(BitNs);
    rxd = 1'b1;
    #(BitNs);
    rxd = 1'b0;
    #(2.5 * BitNs);
    rst_n = 1'b0;
    rxd   = 1'b1;
    last_good = 8'h00;
    #50;
    check("midreset_idle", {31'b0, idle}, 32'd1);
    #3 rst_n = 1'b1;
    idle_bits(2);
    check_counts("midreset");
    send_good(8'h42, BitNs);
    idle_bits(3);
    check_counts("after_reset");

    // Baud mismatch
    send_good(8'h55, BitNs * 1.02);
    idle_bits(3);
    check_counts("fast_2pct");
    send_good(8'h55, BitNs * 0.98);
    idle_bits(3);
    check_counts("slow_2pct");

    // Random bytes, random rate error, occasional bad stop bit
    for (int k = 0; k < 12; k++) begin
      b     = 8'($urandom_range(0, 255));
      scale = 0.98 + 0.04 * real'($urandom_range(0, 100)) / 100.0;
      if ($urandom_range(0, 3) == 0) begin
        send_frame(b, 1'b0, BitNs * scale);
        exp_fe_n++;
        idle_bits(3);
      end else begin
        send_good(b, BitNs * scale);
        idle_bits($urandom_range(1, 3));
      end
    end
    idle_bits(2);
    check_counts("random");
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
